// File: rtl/ni_inject_routing_buf_if.sv
// Purpose : handshake/bus bundle between the NI packetiser/allocators and the
//           injection routing buffer.
// Ports   : master = packetiser + VA/SA side (drives flits and grants),
//           slave  = ni_inject_routing_buf (drives head flit, requests, status).
interface ni_inject_routing_buf_if #(
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int NUM_VC         = 2
);
  // Packetiser -> buffer
  logic                      Req;
  logic [FLIT_SIZE-1:0]      Flit;
  logic [FLIT_TYPE_SIZE-1:0] FlitType;
  logic                      BroadcastFlit;
  logic                      Avail;

  // Allocator handshakes
  logic [NUM_VC-1:0]         Request_VA_L;
  logic [NUM_VC-1:0]         Grant_VA_FromL;
  logic [NUM_VC-1:0]         Request_SA_L;
  logic [NUM_VC-1:0]         Grant_SA_FromL;

  // Head flit towards the crossbar
  logic [FLIT_SIZE-1:0]      FlitOut;
  logic [FLIT_TYPE_SIZE-1:0] FlitTypeOut;
  logic                      BroadcastFlitL;
  logic [NUM_VC-1:0]         VcOut;

  // Sticky error flags
  logic                      Overflow;
  logic                      ProtoErr;

  modport master (
    output Req, Flit, FlitType, BroadcastFlit, Grant_VA_FromL, Grant_SA_FromL,
    input  Avail, Request_VA_L, Request_SA_L, FlitOut, FlitTypeOut,
           BroadcastFlitL, VcOut, Overflow, ProtoErr
  );

  modport slave (
    input  Req, Flit, FlitType, BroadcastFlit, Grant_VA_FromL, Grant_SA_FromL,
    output Avail, Request_VA_L, Request_SA_L, FlitOut, FlitTypeOut,
           BroadcastFlitL, VcOut, Overflow, ProtoErr
  );
endinterface

// File: rtl/ni_inject_routing_buf.sv
// Purpose : NI injection routing stage; DEPTH-flit FIFO, one VA arbitration per
//           packet, one SA request per flit on the held VC.
// Latency : push at edge t -> head at t+1; header into empty FIFO requests VA in t+1;
//           SA grant in cycle k pops at edge k+1.
// Backpr. : Avail = FIFO not full (registered only); Req while full is dropped
//           and flagged in sticky Overflow.
// Ports   : clk, rst_p (sync active-high), bus (slave modport): Req/Flit/FlitType/
//           BroadcastFlit in, Avail out; Request/Grant VA and SA per VC; head flit
//           FlitOut/FlitTypeOut/BroadcastFlitL, VcOut; sticky Overflow, ProtoErr.
module ni_inject_routing_buf #(
  parameter int ID             = 0,
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int NUM_VC         = 2,
  parameter int DEPTH          = 4
) (
  input  logic                    clk,
  input  logic                    rst_p,
  ni_inject_routing_buf_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Flit type encodings, matching `header/`body/`tail/`header_tail in net_common.h
  localparam logic [FLIT_TYPE_SIZE-1:0] FT_HEADER      = FLIT_TYPE_SIZE'(0);
  localparam logic [FLIT_TYPE_SIZE-1:0] FT_BODY        = FLIT_TYPE_SIZE'(1);
  localparam logic [FLIT_TYPE_SIZE-1:0] FT_TAIL        = FLIT_TYPE_SIZE'(2);
  localparam logic [FLIT_TYPE_SIZE-1:0] FT_HEADER_TAIL = FLIT_TYPE_SIZE'(3);

  // The node ID is informational only; the named block makes a negative ID
  // visible in the elaborated hierarchy without affecting logic.
  if (ID < 0) begin : g_negative_node_id
  end

  typedef struct packed {
    logic [FLIT_SIZE-1:0]      flit;
    logic [FLIT_TYPE_SIZE-1:0] typ;
    logic                      bc;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VA_WAIT = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_p1;
  logic [CW-1:0]     count, count_n;
  state_t            state, state_n;
  logic [NUM_VC-1:0] vc, vc_n;
  logic              overflow, proto_err;

  entry_t            head;
  logic              empty, full, push, pop, proto_set;
  logic [NUM_VC-1:0] grant_vc;
  logic [NUM_VC-1:0] req_va, req_sa;
  logic              nxt_hdr;

  function automatic logic is_hdr(input logic [FLIT_TYPE_SIZE-1:0] t);
    return (t == FT_HEADER) || (t == FT_HEADER_TAIL);
  endfunction

  function automatic logic is_tail(input logic [FLIT_TYPE_SIZE-1:0] t);
    return (t == FT_TAIL) || (t == FT_HEADER_TAIL);
  endfunction

  // Lowest set bit, one-hot (zero if none set).
  function automatic logic [NUM_VC-1:0] lowest_bit(input logic [NUM_VC-1:0] v);
    logic [NUM_VC-1:0] r;
    r = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign head      = mem[rd_ptr];
  assign rd_ptr_p1 = rd_ptr + PW'(1);
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign push      = bus.Req && !full;

  // Requests and pop decision for the current state.
  always_comb begin
    req_va    = '0;
    req_sa    = '0;
    pop       = 1'b0;
    proto_set = 1'b0;
    grant_vc  = lowest_bit(bus.Grant_VA_FromL);
    unique case (state)
      IDLE: begin
        // A non-header at the head of an unallocated FIFO is discarded.
        if (!empty && !is_hdr(head.typ)) begin
          pop       = 1'b1;
          proto_set = 1'b1;
        end
      end
      VA_WAIT: begin
        if (|bus.Grant_VA_FromL) begin
          // Request drops in the grant cycle; SA is requested on the new VC at once.
          req_sa = grant_vc;
          pop    = |(bus.Grant_SA_FromL & grant_vc);
        end else begin
          req_va = '1;
        end
      end
      ACTIVE: begin
        if (!empty) begin
          req_sa = vc;
          pop    = |(bus.Grant_SA_FromL & vc);
        end
      end
      default: ;
    endcase
  end

  // Whether the flit at the head after this edge will be a header; lets a
  // following packet request VA in the first cycle it sits at the head.
  always_comb begin
    nxt_hdr = 1'b0;
    if (pop) begin
      if (count > CW'(1)) begin
        nxt_hdr = is_hdr(mem[rd_ptr_p1].typ);
      end else if (push) begin
        nxt_hdr = is_hdr(bus.FlitType);
      end
    end else if (empty && push) begin
      nxt_hdr = is_hdr(bus.FlitType);
    end
  end

  // Next state and VC assignment.
  always_comb begin
    state_n = state;
    vc_n    = vc;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (is_hdr(head.typ)) state_n = VA_WAIT;
        end else if (nxt_hdr) begin
          state_n = VA_WAIT;
        end
      end
      VA_WAIT: begin
        if (|bus.Grant_VA_FromL) begin
          vc_n    = grant_vc;
          state_n = ACTIVE;
        end
      end
      ACTIVE: ;
      default: state_n = IDLE;
    endcase
    // End of packet: release the VC (a header_tail popped in the VA grant
    // cycle therefore never shows a VC).
    if (pop && state != IDLE && is_tail(head.typ)) begin
      vc_n    = '0;
      state_n = nxt_hdr ? VA_WAIT : IDLE;
    end
  end

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{flit: bus.Flit, typ: bus.FlitType, bc: bus.BroadcastFlit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      vc        <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_p1;
      count <= count_n;
      state <= state_n;
      vc    <= vc_n;
      if (bus.Req && full) overflow  <= 1'b1;
      if (proto_set)       proto_err <= 1'b1;
    end
  end

  assign bus.Avail          = !full;
  assign bus.Request_VA_L   = req_va;
  assign bus.Request_SA_L   = req_sa;
  assign bus.FlitOut        = head.flit;
  assign bus.FlitTypeOut    = head.typ;
  assign bus.BroadcastFlitL = head.bc;
  assign bus.VcOut          = vc;
  assign bus.Overflow       = overflow;
  assign bus.ProtoErr       = proto_err;

endmodule
